// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcode encoding and ALU result bundle.
package alu_pkg;

  localparam int ALU_DW = 4;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_DIV  = 3'b011,
    OP_MOD  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_GT   = 3'b111
  } op_e;

  // Result is one bit wider than the operands so add and shift-left never lose a bit.
  typedef struct packed {
    logic [ALU_DW:0] data;
    logic            err;
  } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: unsigned ops evaluated at DW+1 bits; divide/modulo by zero
// saturate the result to all ones and raise err.
module alu_core
  import alu_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_e           sel,
  output alu_res_t      res
);

  logic [DW:0] ax, bx;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  always_comb begin
    res.data = '0;
    res.err  = 1'b0;
    unique case (sel)
      OP_PASS: res.data = ax;
      OP_ADD:  res.data = ax + bx;
      OP_SUB:  res.data = ax - bx;
      OP_DIV: begin
        if (b == '0) begin
          res.data = '1;
          res.err  = 1'b1;
        end else begin
          res.data = ax / bx;
        end
      end
      OP_MOD: begin
        if (b == '0) begin
          res.data = '1;
          res.err  = 1'b1;
        end else begin
          res.data = ax % bx;
        end
      end
      OP_SHL:  res.data = {a, 1'b0};
      OP_SHR:  res.data = ax >> 1;
      OP_GT:   res.data = {{DW{1'b0}}, (a > b)};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// registered, ID-tagged result that supports take-and-accept in the same cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_sel,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW:0]   res_data,
  output logic          res_id,
  output logic          res_err
);

  logic          last;
  logic          can_accept;
  logic          grant0, grant1;
  logic          accept;
  logic [DW-1:0] mux_a, mux_b;
  logic [2:0]    mux_sel;
  alu_res_t      alu_res;

  // last == 1 means requester 1 was served most recently, so requester 0 wins a tie.
  assign can_accept = ~res_valid | res_ready;
  assign grant0     = req0_valid & (~req1_valid | last);
  assign grant1     = req1_valid & (~req0_valid | ~last);
  assign req0_ready = grant0 & can_accept & ~reset;
  assign req1_ready = grant1 & can_accept & ~reset;
  assign accept     = req0_ready | req1_ready;

  assign mux_a   = grant1 ? req1_a   : req0_a;
  assign mux_b   = grant1 ? req1_b   : req0_b;
  assign mux_sel = grant1 ? req1_sel : req0_sel;

  alu_core #(.DW(DW)) u_alu (
    .a   (mux_a),
    .b   (mux_b),
    .sel (op_e'(mux_sel)),
    .res (alu_res)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
      last      <= 1'b1;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= alu_res.data;
      res_id    <= grant1;
      res_err   <= alu_res.err;
      last      <= grant1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  a_one_ready: assert property (@(posedge clock) disable iff (reset)
    !(req0_ready && req1_ready));

  a_hold: assert property (@(posedge clock) disable iff (reset)
    (res_valid && !res_ready) |=> ($stable(res_data) && $stable(res_id) && $stable(res_err)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench: driver predicts grants and pushes expected results,
// a monitor pops and compares whenever a result is taken.
module tb_alu_arbiter;

  typedef struct {
    bit       v;
    bit [3:0] a;
    bit [3:0] b;
    bit [2:0] s;
  } op_t;

  typedef struct {
    bit [4:0] d;
    bit       id;
    bit       err;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_sel = '0, req1_sel = '0;
  logic       res_valid, res_id, res_err;
  logic       res_ready = 1'b0;
  logic [4:0] res_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  op_t  p[2];
  exp_t sb[$];
  int   m_last = 1;
  bit   m_full = 1'b0;

  bit       held_ok = 1'b0;
  bit [4:0] hd;
  bit       hid, herr;
  exp_t     e;

  alu_arbiter #(.DW(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_err(res_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode table, result taken mod 32.
  function automatic exp_t ref_op(input op_t o, input int id);
    exp_t r;
    int a = o.a, b = o.b, v = 0;
    bit err = 0;
    case (o.s)
      0: v = a;
      1: v = a + b;
      2: v = (a - b + 32) % 32;
      3: if (b == 0) begin v = 31; err = 1; end else v = a / b;
      4: if (b == 0) begin v = 31; err = 1; end else v = a % b;
      5: v = a * 2;
      6: v = a / 2;
      default: v = (a > b) ? 1 : 0;
    endcase
    r.d = v[4:0];
    r.id = id[0];
    r.err = err;
    return r;
  endfunction

  task automatic set_op(input int i, input int a, input int b, input int s);
    p[i].v = 1; p[i].a = a[3:0]; p[i].b = b[3:0]; p[i].s = s[2:0];
  endtask

  task automatic rand_op(input int i);
    int b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
    set_op(i, $urandom_range(0, 15), b, $urandom_range(0, 7));
  endtask

  // One clock of stimulus; the model decides who should get ready and what comes out.
  task automatic cycle(input bit rst, input bit rr);
    int w;
    bit can;
    @(posedge clock);
    #2;
    if (reset) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_err", res_err, 0);
    end
    reset = rst;
    res_ready = rr;
    req0_valid = p[0].v; req0_a = p[0].a; req0_b = p[0].b; req0_sel = p[0].s;
    req1_valid = p[1].v; req1_a = p[1].a; req1_b = p[1].b; req1_sel = p[1].s;
    #1;
    can = !m_full || rr;
    w = -1;
    if (p[0].v && p[1].v) w = (m_last == 1) ? 0 : 1;
    else if (p[0].v) w = 0;
    else if (p[1].v) w = 1;
    if (rst || !can) w = -1;
    chk("req0_ready", req0_ready, (w == 0) ? 1 : 0);
    chk("req1_ready", req1_ready, (w == 1) ? 1 : 0);
    if (rst) begin
      m_full = 0; m_last = 1; sb.delete();
    end else if (w >= 0) begin
      sb.push_back(ref_op(p[w], w));
      m_full = 1; m_last = w; p[w].v = 0;
    end else if (rr) begin
      m_full = 0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (p[0].v || p[1].v); k++) cycle(0, 1);
    if (p[0].v || p[1].v) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: pending requests still %0d/%0d, required 0/0", p[0].v, p[1].v);
      p[0].v = 0; p[1].v = 0;
    end
    cycle(0, 1);
    cycle(0, 1);
  endtask

  // Monitor: a result is consumed at the edge following a negedge with valid & ready.
  initial begin
    forever begin
      @(negedge clock);
      if (reset || !res_valid) begin
        held_ok = 0;
      end else begin
        if (held_ok) begin
          chk("hold_data", res_data, hd);
          chk("hold_id", res_id, hid);
          chk("hold_err", res_err, herr);
        end
        if (res_ready) begin
          held_ok = 0;
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: data %0d id %0d with empty scoreboard", res_data, res_id);
          end else begin
            e = sb.pop_front();
            chk("res_data", res_data, e.d);
            chk("res_id", res_id, e.id);
            chk("res_err", res_err, e.err);
          end
        end else begin
          held_ok = 1; hd = res_data; hid = res_id; herr = res_err;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    p[0] = '{0, 0, 0, 0};
    p[1] = '{0, 0, 0, 0};

    // Reset with both requesters pending, then requester 0 wins the first tie
    rand_op(0); rand_op(1);
    cycle(1, 1); cycle(1, 1);
    drain();

    // 3+2 and wrapping 2-3
    set_op(0, 3, 2, 1); drain();
    set_op(0, 2, 3, 2); drain();

    // Continuous contention: ids must alternate
    for (int k = 0; k < 6; k++) begin
      if (!p[0].v) rand_op(0);
      if (!p[1].v) rand_op(1);
      cycle(0, 1);
    end
    drain();

    // Backpressure for 3 cycles, then take and accept together
    rand_op(0); rand_op(1);
    cycle(0, 0); cycle(0, 0); cycle(0, 0); cycle(0, 0);
    cycle(0, 1);
    drain();

    // Divide/modulo by zero and a regular modulo
    set_op(1, 7, 0, 3); drain();
    set_op(1, 7, 0, 4); drain();
    set_op(1, 7, 2, 4); drain();

    // Reset while a result is held under backpressure
    rand_op(0);
    cycle(0, 0); cycle(0, 0);
    cycle(1, 0);
    rand_op(0); rand_op(1);
    cycle(0, 1);
    drain();

    // Random traffic with random backpressure and occasional reset
    for (int k = 0; k < 2000; k++) begin
      if (!p[0].v && $urandom_range(0, 9) < 6) rand_op(0);
      if (!p[1].v && $urandom_range(0, 9) < 6) rand_op(1);
      cycle(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    drain();
    cycle(0, 1);

    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
